// File: rtl/mcu_clkrst_seq.sv
// Clock-enable divider channels and sequenced reset for the MCU top level.
// Each channel yields a strobe and square wave; reset release waits for lock and stretch.
module mcu_clkrst_seq #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 16,
  parameter int DIV_RST   = 16000,
  parameter int RST_TICKS = 3,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lock_i,
  input  logic              ext_rst_n_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  output logic [NUM_CH-1:0] ce_o,
  output logic [NUM_CH-1:0] sq_o,
  output logic              rst_n_o,
  output logic [1:0]        state_o
);

  localparam int TK_W = (RST_TICKS > 1) ? $clog2(RST_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_WAIT    = 2'd1,
    S_STRETCH = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_ce;
    logic             r_sq;
    logic [CNT_W-1:0] w_eff;
    logic             w_wrap;
    logic             w_hi;
    logic             w_sel;

    // divisors below 2 cannot give a strobe and a square wave, so clamp
    assign w_eff  = (r_div < CNT_W'(2)) ? CNT_W'(2) : r_div;
    assign w_wrap = (r_cnt == (w_eff - CNT_W'(1)));
    assign w_hi   = (r_cnt >= (w_eff >> 1));
    assign w_sel  = cfg_we_i && (cfg_ch_i == CH_W'(g));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt      <= '0;
        r_div      <= CNT_W'(DIV_RST);
        r_pend     <= '0;
        r_pend_vld <= 1'b0;
        r_ce       <= 1'b0;
        r_sq       <= 1'b0;
      end else begin
        r_ce <= w_wrap;
        r_sq <= w_hi;
        if (w_wrap) begin
          r_cnt <= '0;
          if (r_pend_vld) r_div <= r_pend;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        // a write on the wrap cycle stays pending for the following wrap
        if (w_sel) begin
          r_pend     <= cfg_div_i;
          r_pend_vld <= 1'b1;
        end else if (w_wrap) begin
          r_pend_vld <= 1'b0;
        end
      end
    end

    assign ce_o[g] = r_ce;
    assign sq_o[g] = r_sq;
  end

  logic r_lk_s1;
  logic r_lk_s2;
  logic r_bt_s1;
  logic r_bt_s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lk_s1 <= 1'b0;
      r_lk_s2 <= 1'b0;
      r_bt_s1 <= 1'b0;
      r_bt_s2 <= 1'b0;
    end else begin
      r_lk_s1 <= lock_i;
      r_lk_s2 <= r_lk_s1;
      r_bt_s1 <= ext_rst_n_i;
      r_bt_s2 <= r_bt_s1;
    end
  end

  state_t          r_state;
  state_t          w_next;
  logic [TK_W-1:0] r_tick;
  logic            w_ok;
  logic            w_last;

  assign w_ok   = r_lk_s2 & r_bt_s2;
  assign w_last = ce_o[0] && (r_tick == TK_W'(RST_TICKS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_RESET;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RESET:   w_next = S_WAIT;
      S_WAIT:    if (w_ok) w_next = S_STRETCH;
      S_STRETCH: begin
        if (!w_ok)       w_next = S_WAIT;
        else if (w_last) w_next = S_RUN;
      end
      S_RUN:     if (!w_ok) w_next = S_WAIT;
      default:   w_next = S_RESET;
    endcase
  end

  // count only while stretching with lock held; any other state restarts it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tick <= '0;
    end else if ((r_state == S_STRETCH) && w_ok) begin
      if (ce_o[0]) r_tick <= r_tick + TK_W'(1);
    end else begin
      r_tick <= '0;
    end
  end

  always_comb begin
    rst_n_o = (r_state == S_RUN);
    state_o = r_state;
  end

endmodule
